coin_scoreboard: RTL and testbench
==================================

COIN_SCOREBOARD -- requirements
Module: coin_scoreboard

Interface
REQ-001 SHALL have parameter NUM_COINS, default 3, number of coin touch inputs (legal range 1..9).
REQ-002 SHALL have parameter TIME_LIMIT, default 99, level time in seconds (legal range 1..99).
REQ-003 SHALL have parameter CLK_HZ, default 25_000_000, vga_clock frequency used for the 1 s tick.
REQ-004 SHALL have port vga_clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port touch, input, NUM_COINS, level-high per-coin overlap flags from the coin detectors.
REQ-007 SHALL have port start, input, 1, level-high request to begin the level (jump button).
REQ-008 SHALL have port restart, input, 1, level-high request to return to IDLE from WON or TIMEOUT.
REQ-009 SHALL have port collected, output, NUM_COINS, sticky mask of coins already taken.
REQ-010 SHALL have port coin_count, output, 4, number of set bits in collected.
REQ-011 SHALL have port playing / level_complete / time_up, output, 1 each, state flags.
REQ-012 SHALL have ports hex0, hex1, hex2, output, 7 each, active-low segments (bit0=a..bit6=g): time ones, time tens, coin_count.
REQ-013 SHALL have port leds, output, 10: [NUM_COINS-1:0]=collected, [8]=time_up, [9]=level_complete, rest 0.

Function
REQ-014 SHALL implement FSM states IDLE, PLAYING, WON, TIMEOUT.
REQ-015 IDLE: timer held at TIME_LIMIT, prescaler 0, touch ignored; start=1 -> PLAYING next cycle.
REQ-016 PLAYING: touch sampled into touch_q each cycle; edge = touch & ~touch_q & ~collected; each edge bit sets its collected bit in the same clock edge (collected visible 1 cycle after touch first sampled high).
REQ-017 SHALL count each coin once; touch held high or re-asserted after collection has no effect.
REQ-018 Multiple coin edges in one cycle SHALL all be recorded in that cycle.
REQ-019 coin_count SHALL be registered popcount of collected, lagging collected by 1 cycle.
REQ-020 Prescaler SHALL count 0..CLK_HZ-1 only in PLAYING; at CLK_HZ-1 it wraps to 0 and issues a 1-cycle tick.
REQ-021 Time SHALL be held as two BCD digits; tick decrements ones, ones 0 -> 9 with tens decrement; never below 00.
REQ-022 PLAYING -> WON when collected becomes all-ones; PLAYING -> TIMEOUT when tick occurs with time 01.
REQ-023 Last coin edge and final tick in same cycle SHALL resolve to WON; time still decrements to 00.
REQ-024 WON/TIMEOUT: collected, time and prescaler frozen, touch ignored; restart=1 -> IDLE next cycle, clearing collected, coin_count, touch_q, prescaler, time=TIME_LIMIT.
REQ-025 start in PLAYING/WON/TIMEOUT and restart in IDLE/PLAYING SHALL be ignored.
REQ-026 playing=1 iff PLAYING, level_complete=1 iff WON, time_up=1 iff TIMEOUT; all registered.
REQ-027 hex outputs SHALL be registered decodes of digits 0..9; values above 9 shall show blank (all 1s).

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, collected=0, coin_count=0, touch_q=0, prescaler=0, time=TIME_LIMIT, all flags 0, hex showing TIME_LIMIT and 0, regardless of state or in-flight tick.
REQ-029 Reset SHALL take priority over start, restart, touch and tick in the same cycle.

Structure
REQ-030 Shared package game_pkg SHALL hold the state enum, tile codes (BDR, SKY, BLK, GND, TKN) and segment blank constant.
REQ-031 SHALL instantiate sub-module seg7_decoder (4-bit BCD in, 7-bit active-low out) three times.

Verification (CLK_HZ=10, TIME_LIMIT=3, NUM_COINS=3)
REQ-032 Reset, start pulse, touch[0] high 5 cycles -> collected=001 one cycle after, coin_count=1, stays 1 after release and re-touch.
REQ-033 touch=110 same cycle -> collected=110 in 1 cycle, coin_count=2 next cycle.
REQ-034 No touches for 30 cycles in PLAYING -> time 3,2,1,0 on ticks every 10 cycles, time_up=1, hex0=0x40 (0), leds[8]=1.
REQ-035 Third coin edge on cycle of final tick -> level_complete=1, time_up=0, hex0 shows 0.
REQ-036 reset=0 mid-PLAYING with collected=011 -> next cycle IDLE, collected=0, time=3, flags 0; then restart=1 in WON -> IDLE with all cleared.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the coin scoreboard and level logic.
// Holds the FSM state enum, tile codes and 7-segment constants.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_WON     = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [2:0] BDR = 3'd0;
    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] BLK = 3'd2;
    localparam logic [2:0] GND = 3'd3;
    localparam logic [2:0] TKN = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern (bit0=a .. bit6=g).
// Codes above 9 show a blank digit.
module seg7_decoder
    import game_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup; the caller registers the result
    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_bcd)
            4'd0:    o_seg = 7'h40;
            4'd1:    o_seg = 7'h79;
            4'd2:    o_seg = 7'h24;
            4'd3:    o_seg = 7'h30;
            4'd4:    o_seg = 7'h19;
            4'd5:    o_seg = 7'h12;
            4'd6:    o_seg = 7'h02;
            4'd7:    o_seg = 7'h78;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h10;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/coin_scoreboard.sv
// Level scoreboard: sticky coin collection, BCD countdown timer,
// IDLE/PLAYING/WON/TIMEOUT control and registered display outputs.
module coin_scoreboard
    import game_pkg::*;
#(
    parameter int NUM_COINS  = 3,
    parameter int TIME_LIMIT = 99,
    parameter int CLK_HZ     = 25_000_000
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] touch,
    input  logic                 start,
    input  logic                 restart,
    output logic [NUM_COINS-1:0] collected,
    output logic [3:0]           coin_count,
    output logic                 playing,
    output logic                 level_complete,
    output logic                 time_up,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic [9:0]           leds
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0] TL_ONES = 4'(TIME_LIMIT % 10);
    localparam logic [3:0] TL_TENS = 4'(TIME_LIMIT / 10);
    localparam logic [NUM_COINS-1:0] ALL_COINS = '1;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_COINS-1:0] r_collected;
    logic [NUM_COINS-1:0] r_touch_q;
    logic [NUM_COINS-1:0] w_edge;
    logic [PW-1:0]        r_presc;
    logic                 w_tick;
    logic                 w_last_sec;
    logic                 w_clear;
    logic [3:0]           r_ones;
    logic [3:0]           r_tens;
    logic [3:0]           r_count;
    logic [3:0]           w_ones_nxt;
    logic [3:0]           w_tens_nxt;
    logic [3:0]           w_cnt_nxt;
    logic [3:0]           w_pop;
    logic                 r_playing;
    logic                 r_won;
    logic                 r_tup;
    logic [6:0]           r_hex0;
    logic [6:0]           r_hex1;
    logic [6:0]           r_hex2;
    logic [6:0]           w_seg0;
    logic [6:0]           w_seg1;
    logic [6:0]           w_seg2;
    logic [9:0]           w_leds;

    // Rising touches on coins not yet taken, only while playing
    always_comb begin
        w_edge     = '0;
        w_tick     = 1'b0;
        w_last_sec = (r_tens == 4'd0) && (r_ones == 4'd1);
        w_clear    = ((r_state == S_WON) || (r_state == S_TIMEOUT)) && restart;
        if (r_state == S_PLAY) begin
            w_edge = touch & ~r_touch_q & ~r_collected;
            w_tick = (r_presc == PRE_MAX);
        end
    end

    // Next state; a last coin beats a simultaneous final tick
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_PLAY;
            end
            S_PLAY: begin
                if ((r_collected | w_edge) == ALL_COINS) w_next = S_WON;
                else if (w_tick && w_last_sec) w_next = S_TIMEOUT;
            end
            S_WON, S_TIMEOUT: begin
                if (restart) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Next timer digits and coin count, with reset folded in
    always_comb begin
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        w_pop      = 4'd0;
        for (int i = 0; i < NUM_COINS; i++) begin
            w_pop = w_pop + 4'(r_collected[i]);
        end
        w_cnt_nxt = w_pop;
        if (!reset || w_clear) begin
            w_cnt_nxt = 4'd0;
        end
        if (!reset || w_clear || (r_state == S_IDLE)) begin
            w_ones_nxt = TL_ONES;
            w_tens_nxt = TL_TENS;
        end else if (w_tick) begin
            if (r_ones != 4'd0) begin
                w_ones_nxt = r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
                w_ones_nxt = 4'd9;
                w_tens_nxt = r_tens - 4'd1;
            end
        end
    end

    seg7_decoder u_seg_ones (.i_bcd(w_ones_nxt), .o_seg(w_seg0));
    seg7_decoder u_seg_tens (.i_bcd(w_tens_nxt), .o_seg(w_seg1));
    seg7_decoder u_seg_cnt  (.i_bcd(w_cnt_nxt),  .o_seg(w_seg2));

    // Control state, coin mask, touch history and prescaler
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_collected <= '0;
            r_touch_q   <= '0;
            r_presc     <= '0;
            r_playing   <= 1'b0;
            r_won       <= 1'b0;
            r_tup       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_playing <= (w_next == S_PLAY);
            r_won     <= (w_next == S_WON);
            r_tup     <= (w_next == S_TIMEOUT);
            if (r_state == S_PLAY) begin
                r_touch_q   <= touch;
                r_collected <= r_collected | w_edge;
                r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            end else if (w_clear) begin
                r_touch_q   <= '0;
                r_collected <= '0;
                r_presc     <= '0;
            end
        end
    end

    // Digits, count and segment patterns; next values already honour reset
    always_ff @(posedge vga_clock) begin
        r_ones  <= w_ones_nxt;
        r_tens  <= w_tens_nxt;
        r_count <= w_cnt_nxt;
        r_hex0  <= w_seg0;
        r_hex1  <= w_seg1;
        r_hex2  <= w_seg2;
    end

    // LED map; with nine coins the time_up lamp takes bit 8
    always_comb begin
        w_leds                  = '0;
        w_leds[NUM_COINS-1:0]   = r_collected;
        w_leds[8]               = r_tup;
        w_leds[9]               = r_won;
    end

    assign collected      = r_collected;
    assign coin_count     = r_count;
    assign playing        = r_playing;
    assign level_complete = r_won;
    assign time_up        = r_tup;
    assign hex0           = r_hex0;
    assign hex1           = r_hex1;
    assign hex2           = r_hex2;
    assign leds           = w_leds;

endmodule

// File: tb/tb_coin_scoreboard.sv
// Directed self-checking bench for coin_scoreboard
// (CLK_HZ=10, TIME_LIMIT=3, NUM_COINS=3).
module tb_coin_scoreboard;

    logic       vga_clock = 1'b0;
    logic       reset     = 1'b0;
    logic [2:0] touch     = 3'b000;
    logic       start     = 1'b0;
    logic       restart   = 1'b0;
    logic [2:0] collected;
    logic [3:0] coin_count;
    logic       playing;
    logic       level_complete;
    logic       time_up;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [9:0] leds;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;

    coin_scoreboard #(
        .NUM_COINS (3),
        .TIME_LIMIT(3),
        .CLK_HZ    (10)
    ) dut (
        .vga_clock     (vga_clock),
        .reset         (reset),
        .touch         (touch),
        .start         (start),
        .restart       (restart),
        .collected     (collected),
        .coin_count    (coin_count),
        .playing       (playing),
        .level_complete(level_complete),
        .time_up       (time_up),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .leds          (leds)
    );

    always #5 vga_clock = ~vga_clock;

    // Advance n rising edges, settle 1 time unit past the last one
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        ticks(2);
        chk("rst_collected", 32'(collected), 32'd0);
        chk("rst_count", 32'(coin_count), 32'd0);
        chk("rst_flags", {29'd0, playing, level_complete, time_up}, 32'd0);
        chk("rst_hex0", 32'(hex0), 32'(S3));
        chk("rst_hex1", 32'(hex1), 32'(S0));
        chk("rst_hex2", 32'(hex2), 32'(S0));
        chk("rst_leds", 32'(leds), 32'd0);

        // Single coin, held then re-touched
        reset = 1'b1;
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        chk("a_playing", 32'(playing), 32'd1);
        touch = 3'b001;
        ticks(1);
        chk("a_coll_1cyc", 32'(collected), 32'd1);
        chk("a_cnt_lag", 32'(coin_count), 32'd0);
        ticks(1);
        chk("a_cnt", 32'(coin_count), 32'd1);
        ticks(3);
        touch = 3'b000;
        ticks(1);
        touch = 3'b001;
        ticks(2);
        touch = 3'b000;
        chk("a_coll_hold", 32'(collected), 32'd1);
        chk("a_cnt_hold", 32'(coin_count), 32'd1);
        chk("a_hex2", 32'(hex2), 32'(S1));

        // Two coins in one cycle; restart/start ignored while playing
        reset = 1'b0;
        ticks(1);
        reset = 1'b1;
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        touch = 3'b110;
        ticks(1);
        chk("b_coll", 32'(collected), 32'd6);
        chk("b_cnt_lag", 32'(coin_count), 32'd0);
        ticks(1);
        touch = 3'b000;
        chk("b_cnt", 32'(coin_count), 32'd2);
        chk("b_hex2", 32'(hex2), 32'(S2));
        restart = 1'b1;
        start = 1'b1;
        ticks(1);
        restart = 1'b0;
        start = 1'b0;
        chk("b_restart_ign", 32'(playing), 32'd1);
        chk("b_coll_kept", 32'(collected), 32'd6);

        // Timeout after 30 cycles
        reset = 1'b0;
        ticks(1);
        reset = 1'b1;
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        ticks(9);
        chk("c_t3_hex0", 32'(hex0), 32'(S3));
        chk("c_t3_hex1", 32'(hex1), 32'(S0));
        ticks(1);
        chk("c_t2_hex0", 32'(hex0), 32'(S2));
        ticks(10);
        chk("c_t1_hex0", 32'(hex0), 32'(S1));
        ticks(9);
        chk("c_pre_to", {30'd0, playing, time_up}, 32'd2);
        ticks(1);
        chk("c_to_flags", {29'd0, playing, level_complete, time_up}, 32'd1);
        chk("c_to_hex0", 32'(hex0), 32'(S0));
        chk("c_to_leds", 32'(leds), 32'h100);
        touch = 3'b111;
        start = 1'b1;
        ticks(12);
        touch = 3'b000;
        start = 1'b0;
        chk("c_frozen_tu", 32'(time_up), 32'd1);
        chk("c_frozen_coll", 32'(collected), 32'd0);
        chk("c_frozen_hex0", 32'(hex0), 32'(S0));
        restart = 1'b1;
        ticks(1);
        restart = 1'b0;
        chk("c_rs_flags", {29'd0, playing, level_complete, time_up}, 32'd0);
        chk("c_rs_hex0", 32'(hex0), 32'(S3));

        // Last coin on the final tick wins
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        touch = 3'b011;
        ticks(1);
        touch = 3'b000;
        ticks(28);
        chk("d_pre_hex0", 32'(hex0), 32'(S1));
        chk("d_pre_play", 32'(playing), 32'd1);
        touch = 3'b100;
        ticks(1);
        touch = 3'b000;
        chk("d_won_flags", {29'd0, playing, level_complete, time_up}, 32'd2);
        chk("d_won_hex0", 32'(hex0), 32'(S0));
        chk("d_won_coll", 32'(collected), 32'd7);
        ticks(1);
        chk("d_won_cnt", 32'(coin_count), 32'd3);
        chk("d_won_hex2", 32'(hex2), 32'(S3));
        chk("d_won_leds", 32'(leds), 32'h207);
        restart = 1'b1;
        ticks(1);
        restart = 1'b0;
        chk("d_rs_coll", 32'(collected), 32'd0);
        chk("d_rs_cnt", 32'(coin_count), 32'd0);
        chk("d_rs_flags", {29'd0, playing, level_complete, time_up}, 32'd0);
        chk("d_rs_hex0", 32'(hex0), 32'(S3));
        chk("d_rs_hex2", 32'(hex2), 32'(S0));

        // Reset mid-play has priority over start/restart/touch
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        touch = 3'b011;
        ticks(1);
        touch = 3'b000;
        chk("e_coll", 32'(collected), 32'd3);
        ticks(2);
        reset = 1'b0;
        start = 1'b1;
        restart = 1'b1;
        touch = 3'b100;
        ticks(1);
        reset = 1'b1;
        start = 1'b0;
        restart = 1'b0;
        touch = 3'b000;
        chk("e_rst_coll", 32'(collected), 32'd0);
        chk("e_rst_flags", {29'd0, playing, level_complete, time_up}, 32'd0);
        chk("e_rst_hex0", 32'(hex0), 32'(S3));
        ticks(1);
        chk("e_rst_cnt", 32'(coin_count), 32'd0);

        // Prescaler restarts from zero after reset
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        ticks(9);
        chk("e_pre_hex0", 32'(hex0), 32'(S3));
        ticks(1);
        chk("e_tick_hex0", 32'(hex0), 32'(S2));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
